// File: rtl/h_u_seqdiv8_if.sv
// Handshake bundle for h_u_seqdiv8: operand request channel and result channel.
// The divider uses the slave modport; the operand source and result consumer use master.
interface h_u_seqdiv8_if #(
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf
  );
endinterface

// File: rtl/h_u_seqdiv8.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per
// clock. Optional HUSEQDIV_OVF_SHORTCUT_EN sends overflowing operations straight to DONE.
module h_u_seqdiv8 #(
  parameter int unsigned N = 8
) (
  input logic          clk,
  input logic          rst,
  h_u_seqdiv8_if.slave bus
);

  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e          state_q, state_d;
  // Partial remainder R. Its top bit is zero at every register boundary (R < divisor, or a
  // high dividend half that fits in N bits), so only the low N bits are stored.
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvsr_q, dvsr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic [N-1:0]    dvd_hi;
  logic            accept_ovf;
  logic [N:0]      trial;
  logic            trial_ge;
  logic [N-1:0]    trial_diff;

  assign dvd_hi     = bus.dividend[2*N-1:N];
  assign accept_ovf = (bus.divisor == '0) || (dvd_hi >= bus.divisor);

  // N+1-bit compare; the difference fits in N bits whenever it is taken.
  assign trial      = {rem_q, dvd_q[N-1]};
  assign trial_ge   = trial >= {1'b0, dvsr_q};
  assign trial_diff = trial[N-1:0] - dvsr_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          dvsr_d  = bus.divisor;
          dvd_d   = bus.dividend[N-1:0];
          rem_d   = dvd_hi;
          quo_d   = '0;
          cnt_d   = CntW'(N);
          ovf_d   = accept_ovf;
          state_d = StCalc;
`ifdef HUSEQDIV_OVF_SHORTCUT_EN
          if (accept_ovf) begin
            quo_d   = '1;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StDone;
          end
`endif
        end
      end

      StCalc: begin
        rem_d = trial_ge ? trial_diff : trial[N-1:0];
        quo_d = {quo_q[N-2:0], trial_ge};
        dvd_d = {dvd_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          // Iteration contents are meaningless on overflow; present the saturated result.
          if (ovf_q) begin
            quo_d = '1;
            rem_d = '0;
          end
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dvd_q   <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_h_u_seqdiv8.sv
// Scoreboard bench for h_u_seqdiv8: directed cases, backpressure, reset mid-operation and
// randomized operands checked against a plain-arithmetic division model.
module tb_h_u_seqdiv8;
  localparam int N = 8;
`ifdef HUSEQDIV_OVF_SHORTCUT_EN
  localparam int OvfLat = 1;
`else
  localparam int OvfLat = N;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  h_u_seqdiv8_if #(.N(N)) bus ();

  h_u_seqdiv8 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         o;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  endtask

  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t        e;
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    e.acc = 0;
    if (bi == 0 || ai / bi > (1 << N) - 1) begin
      e.q   = '1;
      e.r   = '0;
      e.o   = 1'b1;
      e.lat = OvfLat;
    end else begin
      e.q   = N'(ai / bi);
      e.r   = N'(ai % bi);
      e.o   = 1'b0;
      e.lat = N;
    end
    return e;
  endfunction

  // Monitor: compares every cycle the DUT presents a result; pops on handoff.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        if (!ov_prev) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        check("quotient", 32'(bus.quotient), 32'(sb[0].q));
        check("remainder", 32'(bus.remainder), 32'(sb[0].r));
        check("ovf", 32'(bus.ovf), 32'(sb[0].o));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b, output int acc);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready) begin
      @(negedge clk);
      w++;
      if (w > 2000) timeout("accept");
    end
    e     = model(a, b);
    e.acc = cyc + 1;
    acc   = e.acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
  endtask

  // Issue with out_ready high and check when the block becomes ready again.
  task automatic op_wait(input logic [2*N-1:0] a, input logic [N-1:0] b);
    int   acc;
    int   w;
    exp_t e;
    e = model(a, b);
    issue(a, b, acc);
    @(negedge clk);
    w = 0;
    while (!bus.in_ready) begin
      @(negedge clk);
      w++;
      if (w > 100) timeout("in_ready_return");
    end
    check("in_ready_return", 32'(cyc - acc), 32'(e.lat + 1));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      w++;
      if (w > 20000) timeout("drain");
    end
  endtask

  initial begin
    int          acc;
    int          w;
    int          sel;
    logic [7:0]  b;
    logic [15:0] a;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);

    op_wait(16'd1000, 8'd7);
    op_wait(16'hFE01, 8'd255);
    op_wait(16'h1234, 8'd0);
    op_wait(16'h0700, 8'd7);

    // Backpressure with in_valid pulses while the result is held.
    bus.out_ready = 1'b0;
    issue(16'd12345, 8'd200, acc);
    w = 0;
    while (!bus.out_valid) begin
      @(negedge clk);
      w++;
      if (w > 100) timeout("bp_out_valid");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2) == 0;
      bus.dividend = 16'($urandom);
      bus.divisor  = 8'($urandom);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_handoff_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_handoff_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_queue_empty", 32'(sb.size()), 32'd0);

    // Reset four edges after an accept discards the operation.
    issue(16'h2345, 8'h99, acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_ovf", 32'(bus.ovf), 32'd0);
    op_wait(16'd100, 8'd9);

    // Randomized operands with random consumer backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        b = '0;
        a = 16'($urandom);
      end else if (sel == 1) begin
        b = 8'($urandom);
        a = 16'($urandom);
      end else begin
        b = 8'($urandom_range(1, 255));
        a = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
      end
      issue(a, b, acc);
    end
    drain();
    rdy_rand = 1'b0;
    #1 bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
